// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the decode stage: function codes, ALU opcodes and
// the decode FSM state type.
package cpu_isa_pkg;

  localparam logic [8:0] FN_NOP  = 9'h000;
  localparam logic [8:0] FN_ADD  = 9'h001;
  localparam logic [8:0] FN_AND  = 9'h002;
  localparam logic [8:0] FN_SUB  = 9'h003;
  localparam logic [8:0] FN_OR   = 9'h004;
  localparam logic [8:0] FN_XOR  = 9'h005;
  localparam logic [8:0] FN_MOV  = 9'h006;
  localparam logic [8:0] FN_ADC  = 9'h007;
  localparam logic [8:0] FN_NOT  = 9'h008;
  localparam logic [8:0] FN_SAR  = 9'h009;
  localparam logic [8:0] FN_SLR  = 9'h00A;
  localparam logic [8:0] FN_SAL  = 9'h00B;
  localparam logic [8:0] FN_SLL  = 9'h00C;
  localparam logic [8:0] FN_ROL  = 9'h00D;
  localparam logic [8:0] FN_ROR  = 9'h00E;
  localparam logic [8:0] FN_SHOW = 9'h012;
  localparam logic [8:0] FN_LDI  = 9'h000;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_SHOW = '1;
  localparam logic [4:0] OP_LDI  = 5'h10;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } dec_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field decoder: splits a fetched word into register fields and
// classifies its type/funct into ALU op, write/show enables, illegal and LDI.
module instr_field_decode
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int OP_W    = 5
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    alu_op,
  output logic [REG_AW-1:0]  addr1,
  output logic [REG_AW-1:0]  addr2,
  output logic               write,
  output logic               show,
  output logic               illegal,
  output logic               is_ldi
);

  localparam int FN_W = INSTR_W - 1 - 2*REG_AW;

  logic            typ;
  logic [FN_W-1:0] funct;
  logic [31:0]     fn;

  assign typ   = instr[INSTR_W-1];
  assign funct = instr[INSTR_W-2:2*REG_AW];
  assign addr1 = instr[2*REG_AW-1:REG_AW];
  assign addr2 = instr[REG_AW-1:0];
  // Compare in 32 bits so the fixed 9-bit constants work for any funct width.
  assign fn    = 32'(funct);

  always_comb begin
    alu_op  = '0;
    write   = 1'b0;
    show    = 1'b0;
    illegal = 1'b0;
    is_ldi  = 1'b0;
    if (!typ) begin
      if (fn == 32'(FN_NOP)) begin
        alu_op = OP_W'(OP_NOP);
      end else if (fn >= 32'(FN_ADD) && fn <= 32'(FN_ROR)) begin
        alu_op = OP_W'(funct);
        write  = 1'b1;
      end else if (fn == 32'(FN_SHOW)) begin
        alu_op = '1;
        show   = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end else begin
      if (fn == 32'(FN_LDI)) begin
        is_ldi = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with a one-entry output register and a
// two-word LDI sequence (opcode word, then raw immediate word).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | next accepted word is decoded as an instruction
//   WAIT_IMM | LDI seen; next accepted word is its immediate, not decoded
module decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int OP_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    alu_op,
  output logic [REG_AW-1:0]  addr1,
  output logic [REG_AW-1:0]  addr2,
  output logic [INSTR_W-1:0] imm,
  output logic               has_imm,
  output logic               write,
  output logic               show,
  output logic               illegal,
  output logic               imm_pending
);

  dec_state_e state_q, state_d;
  logic [REG_AW-1:0] ldi_addr_q, ldi_addr_d;

  logic [OP_W-1:0]   dec_alu_op;
  logic [REG_AW-1:0] dec_addr1, dec_addr2;
  logic              dec_write, dec_show, dec_illegal, dec_is_ldi;

  logic               accept;
  logic               valid_d;
  logic [OP_W-1:0]    alu_op_d;
  logic [REG_AW-1:0]  addr1_d, addr2_d;
  logic [INSTR_W-1:0] imm_d;
  logic               has_imm_d, write_d, show_d, illegal_d;

  instr_field_decode #(
    .INSTR_W (INSTR_W),
    .REG_AW  (REG_AW),
    .OP_W    (OP_W)
  ) u_field_decode (
    .instr   (in_instr),
    .alu_op  (dec_alu_op),
    .addr1   (dec_addr1),
    .addr2   (dec_addr2),
    .write   (dec_write),
    .show    (dec_show),
    .illegal (dec_illegal),
    .is_ldi  (dec_is_ldi)
  );

  assign in_ready    = !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign imm_pending = (state_q == WAIT_IMM);

  always_comb begin
    state_d    = state_q;
    ldi_addr_d = ldi_addr_q;
    valid_d    = out_valid;
    alu_op_d   = alu_op;
    addr1_d    = addr1;
    addr2_d    = addr2;
    imm_d      = imm;
    has_imm_d  = has_imm;
    write_d    = write;
    show_d     = show;
    illegal_d  = illegal;

    if (flush) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      alu_op_d  = '0;
      addr1_d   = '0;
      addr2_d   = '0;
      imm_d     = '0;
      has_imm_d = 1'b0;
      write_d   = 1'b0;
      show_d    = 1'b0;
      illegal_d = 1'b0;
    end else if (accept) begin
      if (state_q == WAIT_IMM) begin
        state_d   = IDLE;
        valid_d   = 1'b1;
        alu_op_d  = OP_W'(OP_LDI);
        addr1_d   = ldi_addr_q;
        addr2_d   = '0;
        imm_d     = in_instr;
        has_imm_d = 1'b1;
        write_d   = 1'b1;
        show_d    = 1'b0;
        illegal_d = 1'b0;
      end else if (dec_is_ldi) begin
        // First LDI word produces no bundle; any prior bundle was handshaken.
        state_d    = WAIT_IMM;
        ldi_addr_d = dec_addr1;
        valid_d    = 1'b0;
        alu_op_d   = '0;
        addr1_d    = '0;
        addr2_d    = '0;
        imm_d      = '0;
        has_imm_d  = 1'b0;
        write_d    = 1'b0;
        show_d     = 1'b0;
        illegal_d  = 1'b0;
      end else begin
        valid_d   = 1'b1;
        alu_op_d  = dec_alu_op;
        addr1_d   = dec_addr1;
        addr2_d   = dec_addr2;
        imm_d     = '0;
        has_imm_d = 1'b0;
        write_d   = dec_write;
        show_d    = dec_show;
        illegal_d = dec_illegal;
      end
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ldi_addr_q <= '0;
      out_valid  <= 1'b0;
      alu_op     <= '0;
      addr1      <= '0;
      addr2      <= '0;
      imm        <= '0;
      has_imm    <= 1'b0;
      write      <= 1'b0;
      show       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ldi_addr_q <= ldi_addr_d;
      out_valid  <= valid_d;
      alu_op     <= alu_op_d;
      addr1      <= addr1_d;
      addr2      <= addr2_d;
      imm        <= imm_d;
      has_imm    <= has_imm_d;
      write      <= write_d;
      show       <= show_d;
      illegal    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed plan steps followed by random
// traffic, compared against a transaction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [2:0]  addr1;
  logic [2:0]  addr2;
  logic [15:0] imm;
  logic        has_imm;
  logic        write;
  logic        show;
  logic        illegal;
  logic        imm_pending;

  always #5 clk = ~clk;

  decode_stage #(.INSTR_W(16), .REG_AW(3), .OP_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_op      (alu_op),
    .addr1       (addr1),
    .addr2       (addr2),
    .imm         (imm),
    .has_imm     (has_imm),
    .write       (write),
    .show        (show),
    .illegal     (illegal),
    .imm_pending (imm_pending)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [15:0] imm;
    logic        hi, wr, sh, il;
    bit          ldi;
  } bund_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    m_valid, m_pend;
  int    m_addr;
  bund_t m_b;

  function automatic bund_t ref_decode(input int w);
    bund_t b;
    int typ, fn;
    typ = (w >> 15) & 1;
    fn  = (w >> 6) & 'h1FF;
    b.op = 0; b.imm = 0; b.hi = 0; b.wr = 0; b.sh = 0; b.il = 0; b.ldi = 0;
    b.a1 = 3'((w >> 3) & 7);
    b.a2 = 3'(w & 7);
    if (typ == 0) begin
      if (fn >= 1 && fn <= 14) begin b.op = 5'(fn); b.wr = 1; end
      else if (fn == 'h12) begin b.op = 5'd31; b.sh = 1; end
      else if (fn != 0) b.il = 1;
    end else begin
      if (fn == 0) b.ldi = 1;
      else b.il = 1;
    end
    return b;
  endfunction

  function automatic logic [63:0] pack_b(input bund_t b);
    return 64'({b.op, b.a1, b.a2, b.imm, b.hi, b.wr, b.sh, b.il});
  endfunction

  function automatic logic [63:0] dut_bundle();
    return 64'({alu_op, addr1, addr2, imm, has_imm, write, show, illegal});
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pend = 0; m_addr = 0;
    m_b = ref_decode(0);
  endtask

  task automatic cycle(input logic v, input logic [15:0] w, input logic r, input logic f);
    bit acc, exp_rdy;
    bund_t d;
    in_valid = v; in_instr = w; out_ready = r; flush = f;
    #1;
    exp_rdy = !f && (!m_valid || r);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    #1;
    if (f) begin
      m_pend = 0; m_valid = 0;
    end else if (acc) begin
      if (m_pend) begin
        m_b.op = 5'h10; m_b.a1 = 3'(m_addr); m_b.a2 = 0; m_b.imm = w;
        m_b.hi = 1; m_b.wr = 1; m_b.sh = 0; m_b.il = 0;
        m_valid = 1; m_pend = 0;
      end else begin
        d = ref_decode(int'(w));
        if (d.ldi) begin
          m_pend = 1; m_addr = (int'(w) >> 3) & 7; m_valid = 0;
        end else begin
          m_b = d; m_valid = 1;
        end
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("imm_pending", 64'(imm_pending), 64'(m_pend));
    if (m_valid) chk("bundle", dut_bundle(), pack_b(m_b));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm_pending", 64'(imm_pending), 64'd0);
    chk("rst_bundle", dut_bundle(), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit          v, r, f;
    logic [15:0] w;
    int          sel;
    rst_n = 1'b1; flush = 0; in_valid = 0; in_instr = 0; out_ready = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    // ADD with idle consumer
    cycle(1, 16'h0053, 1, 0);
    chk("add_op", 64'(alu_op), 64'd1);
    chk("add_a1", 64'(addr1), 64'd2);
    chk("add_a2", 64'(addr2), 64'd3);
    chk("add_wr", 64'(write), 64'd1);
    // SHOW
    cycle(1, 16'h0488, 1, 0);
    chk("show_flags", 64'({show, write, alu_op, addr1}), 64'({1'b1, 1'b0, 5'h1F, 3'd1}));
    // LDI two-word sequence
    cycle(1, 16'h8028, 1, 0);
    chk("ldi_first_nobundle", 64'({imm_pending, out_valid}), 64'b10);
    cycle(1, 16'hBEEF, 1, 0);
    chk("ldi_bundle", 64'({alu_op, addr1, imm, has_imm, write}), 64'({5'h10, 3'd5, 16'hBEEF, 1'b1, 1'b1}));
    cycle(0, 16'h0000, 1, 0);
    chk("ldi_single", 64'(out_valid), 64'd0);
    // Illegal encodings
    cycle(1, 16'h0F00, 1, 0);
    chk("ill0", 64'({illegal, write}), 64'b10);
    cycle(1, 16'h8040, 1, 0);
    chk("ill1", 64'({illegal, imm_pending}), 64'b10);
    // NOP
    cycle(1, 16'h001A, 1, 0);
    // Backpressure
    cycle(1, 16'h0053, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0093, 0, 0);
    cycle(1, 16'h0093, 1, 0);
    cycle(1, 16'h00D1, 1, 0);
    cycle(0, 16'h0000, 1, 0);
    // Flush in WAIT_IMM, then ADD
    cycle(1, 16'h8028, 1, 0);
    cycle(1, 16'h1234, 1, 1);
    cycle(1, 16'h0053, 1, 0);
    chk("post_flush_add", 64'({alu_op, has_imm}), 64'({5'd1, 1'b0}));
    // Reset mid-stall
    cycle(1, 16'h0053, 1, 0);
    cycle(0, 16'h0000, 0, 0);
    do_reset();
    cycle(0, 16'h0000, 1, 0);
    // Reset mid-LDI
    cycle(1, 16'h8038, 1, 0);
    do_reset();
    cycle(1, 16'hCAFE, 1, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 29) == 0);
      sel = $urandom_range(0, 5);
      w = 16'($urandom);
      if (sel == 0) w[15:6] = 10'($urandom_range(0, 14));
      else if (sel == 1) w[15:6] = 10'h012;
      else if (sel == 2) w[15:6] = 10'h200;
      else if (sel == 3) w[15:6] = 10'($urandom_range(0, 31));
      cycle(v, w, r, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction decode stage that replaces the purely combinational decoder in the CPU datapath.
- Sits between the instruction fetch path and the register file / ALU.
- Generalised in instruction width and register-address width.
- Implements the second instruction type: a two-word load-immediate (LDI) whose immediate arrives as the next fetched word.
- Adds a one-entry output pipeline register with valid/ready backpressure, an illegal-opcode flag and a synchronous flush.

Parameters:
- INSTR_W, 16, instruction and immediate word width (min 2*REG_AW+2).
- REG_AW, 3, register address width.
- OP_W, 5, ALU opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards pending state and the output register.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  stage accepts a word this cycle.
- in_instr  in  INSTR_W  fetched word (instruction or immediate).
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts bundle.
- alu_op  out  OP_W  ALU operation.
- addr1  out  REG_AW  register field in_instr[2*REG_AW-1:REG_AW] (LDI destination).
- addr2  out  REG_AW  register field in_instr[REG_AW-1:0].
- imm  out  INSTR_W  immediate; 0 when has_imm=0.
- has_imm  out  1  bundle carries an immediate.
- write  out  1  register-file write enable.
- show  out  1  display-register request.
- illegal  out  1  undefined encoding.
- imm_pending  out  1  FSM waiting for an immediate word.

Behaviour:
- Reset: FSM=IDLE; out_valid, imm_pending, all bundle fields = 0.
- Fields: type = in_instr[INSTR_W-1]; funct = in_instr[INSTR_W-2:2*REG_AW].
- Accept: a word is accepted when in_valid && in_ready.
- in_ready = !flush && (!out_valid || out_ready).
- Type 0, funct 0: NOP, alu_op=0, write=0.
- Type 0, funct 1..14: alu_op=funct[OP_W-1:0], write=1. Order: ADD, AND, SUB, OR, XOR, MOV, ADC, NOT, SAR, SLR, SAL, SLL, ROL, ROR.
- Type 0, funct 0x012: SHOW, alu_op=all ones, show=1, write=0.
- Type 0, any other funct: illegal=1, alu_op=0, write=0, show=0.
- Type 1, funct 0: LDI. FSM moves IDLE->WAIT_IMM and latches addr1; no bundle is emitted yet.
- Type 1, any other funct: illegal=1, single-word bundle.
- WAIT_IMM: the next accepted word is taken as raw immediate data (never decoded). Emit alu_op=5'h10, addr1=latched, addr2=0, imm=word, has_imm=1, write=1. FSM returns to IDLE.
- Latency: bundle visible exactly 1 cycle after the accepting edge (after the immediate word for LDI). Throughput 1 bundle/cycle.
- Output hold: while out_valid && !out_ready, every output is held stable and in_ready=0.
- Output release: out_valid clears on handshake unless a new word (other than an LDI first word) is accepted in the same cycle.
- Flush: on the next edge, FSM=IDLE and out_valid=0. Any word presented with flush is dropped (in_ready=0). Flush in WAIT_IMM discards the latched LDI.
- Reset asserted mid-LDI or mid-stall: immediate return to reset values; no partial bundle is ever emitted.
- Unused outputs read 0 in every bundle (no stale fields).

Decomposition:
- Shared package cpu_isa_pkg holds:
  - funct constants (FN_NOP..FN_ROR, FN_SHOW=9'h012, FN_LDI=9'h000);
  - ALU op constants (OP_SHOW='1, OP_LDI=5'h10);
  - state enum {IDLE, WAIT_IMM}.
- One combinational sub-module, instr_field_decode, maps a word to {alu_op, write, show, illegal, is_ldi}.
- decode_stage owns the FSM and the output register.

Test Plan:
- ADD, idle consumer: in_instr=16'h0053 with out_ready=1 -> next cycle out_valid=1, alu_op=1, addr1=2, addr2=3, write=1, illegal=0.
- SHOW: in_instr=16'h0488 -> show=1, write=0, alu_op=5'h1F, addr1=1.
- LDI: 16'h8028 then 16'hBEEF -> imm_pending=1 and no bundle after the first word. Single bundle after the second: alu_op=5'h10, addr1=5, imm=16'hBEEF, has_imm=1, write=1.
- Illegal encodings:
  - 16'h0F00 -> illegal=1, write=0.
  - 16'h8040 -> illegal=1, single bundle, FSM stays IDLE.
- Backpressure: out_ready=0 for 3 cycles after an ADD -> outputs stable and in_ready=0. On release, the next word is accepted the same cycle and back-to-back bundles follow.
- Flush and reset: flush in WAIT_IMM, then 16'h0053 -> no LDI bundle, ADD decoded normally. rst_n low mid-stall -> all outputs 0 asynchronously.
